// File: rtl/fft_out_streamer.sv
// Streams a completed FFT frame out of the result RAM in natural bin order.
// A 4-entry prefetch FIFO with read credits absorbs downstream backpressure.
module fft_out_streamer #(
    parameter int FFT_SIZE      = 1024,
    parameter int DATA_WIDTH    = 16,
    parameter bit HALF_SPECTRUM = 1'b0,
    parameter int SCALE_SHIFT   = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            mem_req_o,
    output logic [$clog2(FFT_SIZE)-1:0]     mem_addr_o,
    input  logic [2*DATA_WIDTH-1:0]         mem_rdata_i,
    output logic                            fft_out_valid_o,
    output logic [2*DATA_WIDTH-1:0]         fft_out_data_o,
    output logic                            fft_out_last_o,
    input  logic                            fft_out_ready_i
);

    localparam int AW    = $clog2(FFT_SIZE);
    localparam int N_OUT = HALF_SPECTRUM ? FFT_SIZE / 2 + 1 : FFT_SIZE;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_OUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           addr_q;
    logic                    rd_vld_q;
    logic                    rd_last_q;
    logic                    done_q;
    logic [2*DATA_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [DEPTH-1:0]        fifo_last_q;
    logic [1:0]              wr_ptr_q;
    logic [1:0]              rd_ptr_q;
    logic [2:0]              count_q;

    logic issue;
    logic push;
    logic pop;
    logic head_last;
    logic fifo_valid;
    logic signed [DATA_WIDTH-1:0] re_in, im_in, re_sh, im_sh;

    // credits cover both buffered words and reads still in the RAM pipeline
    assign issue = (state_q == STREAM) &&
                   ((count_q + {2'b00, rd_vld_q}) < 3'(DEPTH));

    assign push       = rd_vld_q;
    assign fifo_valid = (count_q != 3'd0);
    assign pop        = fifo_valid && fft_out_ready_i;
    assign head_last  = fifo_valid && fifo_last_q[rd_ptr_q];

    assign re_in = mem_rdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
    assign im_in = mem_rdata_i[DATA_WIDTH-1:0];
    assign re_sh = re_in >>> SCALE_SHIFT;
    assign im_sh = im_in >>> SCALE_SHIFT;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = STREAM;
            STREAM:  if (issue && addr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:   if (pop && head_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_vld_q  <= issue;
            rd_last_q <= issue && (addr_q == LAST_ADDR);
            done_q    <= (state_q == DRAIN) && pop && head_last;
            if (state_q == IDLE && start_i) begin
                addr_q <= '0;
            end else if (issue) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= {re_sh, im_sh};
                fifo_last_q[wr_ptr_q] <= rd_last_q;
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            if (push && !pop) begin
                count_q <= count_q + 3'd1;
            end else if (!push && pop) begin
                count_q <= count_q - 3'd1;
            end
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign mem_req_o       = issue;
    assign mem_addr_o      = addr_q;
    assign fft_out_valid_o = fifo_valid;
    assign fft_out_data_o  = fifo_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign fft_out_last_o  = head_last;

endmodule

// File: tb/tb_fft_out_streamer.sv
// Bench for fft_out_streamer: full-spectrum and half-spectrum/scaled instances
// checked against a bin-list model and credit/occupancy rules.
module tb_fft_out_streamer;

    localparam int N = 8;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic [1:0] start, rdy, req, busy, done, vld, lst;
    logic [1:0][2:0]  addr;
    logic [1:0][31:0] rdata, odata;
    logic [31:0] ram [2][N];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 [2];
    int got_n [2];
    logic [31:0] got_d [2][16];
    logic        got_l [2][16];
    int          got_c [2][16];
    int done_n [2], done_c [2];
    int first_req [2], first_vld [2], busy_first [2], busy_last [2];
    int occ [2], infl [2];
    logic stall [2];
    logic [32:0] held [2];

    typedef struct {
        logic [31:0] ram_word;
        logic [31:0] exp_data;
        logic        exp_last;
        int          exp_cyc;
    } vec_t;
    vec_t tab [N];

    fft_out_streamer #(
        .FFT_SIZE(8), .DATA_WIDTH(16), .HALF_SPECTRUM(1'b0), .SCALE_SHIFT(0)
    ) u_full (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start[0]),
        .busy_o(busy[0]), .done_o(done[0]),
        .mem_req_o(req[0]), .mem_addr_o(addr[0]), .mem_rdata_i(rdata[0]),
        .fft_out_valid_o(vld[0]), .fft_out_data_o(odata[0]),
        .fft_out_last_o(lst[0]), .fft_out_ready_i(rdy[0])
    );

    fft_out_streamer #(
        .FFT_SIZE(8), .DATA_WIDTH(16), .HALF_SPECTRUM(1'b1), .SCALE_SHIFT(2)
    ) u_half (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start[1]),
        .busy_o(busy[1]), .done_o(done[1]),
        .mem_req_o(req[1]), .mem_addr_o(addr[1]), .mem_rdata_i(rdata[1]),
        .fft_out_valid_o(vld[1]), .fft_out_data_o(odata[1]),
        .fft_out_last_o(lst[1]), .fft_out_ready_i(rdy[1])
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        for (int g = 0; g < 2; g++) begin
            if (req[g]) rdata[g] <= ram[g][addr[g]];
        end
    end

    function automatic int nout(input int g);
        return (g == 1) ? 5 : 8;
    endfunction

    function automatic int shf(input int g);
        return (g == 1) ? 2 : 0;
    endfunction

    // floor(x / 2^sh) on each signed component
    function automatic logic [31:0] model_word(input logic [31:0] w, input int sh);
        int re, im, d;
        d  = 1 << sh;
        re = int'($signed(w[31:16]));
        im = int'($signed(w[15:0]));
        re = (re < 0) ? -((-re + d - 1) / d) : re / d;
        im = (im < 0) ? -((-im + d - 1) / d) : im / d;
        return {re[15:0], im[15:0]};
    endfunction

    task automatic check(input string name, input bit ok,
                         input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        check(name, act === exp, act, exp);
    endtask

    always @(negedge clk_i) begin : mon
        int rel;
        for (int g = 0; g < 2; g++) begin
            if (!rst_ni) begin
                eq("reset_outputs",
                   {busy[g], done[g], req[g], vld[g], lst[g], addr[g], odata[g]}, 0);
                occ[g]   = 0;
                infl[g]  = 0;
                stall[g] = 1'b0;
            end else begin
                rel = cyc - t0[g];
                if (busy[g]) begin
                    if (busy_first[g] < 0) busy_first[g] = rel;
                    busy_last[g] = rel;
                end
                if (req[g]) begin
                    if (first_req[g] < 0) first_req[g] = rel;
                    check("credit_limit", occ[g] + infl[g] < 4, occ[g] + infl[g], 3);
                    check("addr_range", int'(addr[g]) < nout(g), addr[g], nout(g) - 1);
                end
                eq("valid_vs_occ", vld[g], occ[g] != 0);
                if (stall[g]) eq("stall_hold", {vld[g], lst[g], odata[g]}, {1'b1, held[g]});
                if (vld[g] && first_vld[g] < 0) first_vld[g] = rel;
                if (vld[g] && rdy[g]) begin
                    if (got_n[g] < 16) begin
                        got_d[g][got_n[g]] = odata[g];
                        got_l[g][got_n[g]] = lst[g];
                        got_c[g][got_n[g]] = rel;
                    end
                    got_n[g]++;
                end
                if (done[g]) begin
                    done_n[g]++;
                    done_c[g] = rel;
                end
                stall[g] = vld[g] && !rdy[g];
                held[g]  = {lst[g], odata[g]};
                occ[g]   = occ[g] + infl[g] - ((vld[g] && rdy[g]) ? 1 : 0);
                infl[g]  = req[g] ? 1 : 0;
            end
        end
    end

    task automatic run_frame(input int g, input bit rand_rdy,
                             input int mid_start, input int rst_after);
        got_n[g]      = 0;
        done_n[g]     = 0;
        done_c[g]     = -1;
        first_req[g]  = -1;
        first_vld[g]  = -1;
        busy_first[g] = -1;
        busy_last[g]  = -1;
        @(posedge clk_i);
        #1;
        t0[g]    = cyc;
        start[g] = 1'b1;
        rdy[g]   = rand_rdy ? 1'($urandom_range(0, 2) != 0) : 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_i);
            #1;
            if (done_n[g] > 0) break;
            start[g] = (mid_start > 0) && (cyc - t0[g] == mid_start);
            rdy[g]   = rand_rdy ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            if (rst_after > 0 && got_n[g] >= rst_after) begin
                #1;
                rst_ni = 1'b0;
                #1;
                eq("async_rst_ctrl", {busy, done, req, vld, lst, addr}, 0);
                eq("async_rst_data", {odata[1], odata[0]}, 0);
                start[g] = 1'b0;
                repeat (2) @(posedge clk_i);
                #1;
                rst_ni = 1'b1;
                repeat (12) @(posedge clk_i);
                #1;
                eq("rst_no_done", done_n[g], 0);
                eq("rst_bins_kept", got_n[g], rst_after);
                eq("rst_idle_busy", busy[g], 1'b0);
                return;
            end
        end
        start[g] = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        eq("frame_done_once", done_n[g], 1);
        eq("busy_low_after", busy[g], 1'b0);
    endtask

    task automatic compare_frame(input int g);
        eq("bin_count", got_n[g], nout(g));
        for (int k = 0; k < nout(g) && k < got_n[g] && k < 16; k++) begin
            eq($sformatf("bin%0d_data_i%0d", k, g), got_d[g][k], model_word(ram[g][k], shf(g)));
            eq($sformatf("bin%0d_last_i%0d", k, g), got_l[g][k], k == nout(g) - 1);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        start  = '0;
        rdy    = '0;
        for (int g = 0; g < 2; g++) begin
            t0[g] = 0;
            got_n[g] = 0;
            done_n[g] = 0;
            for (int k = 0; k < N; k++) ram[g][k] = '0;
        end
        for (int k = 0; k < N; k++) begin
            tab[k].ram_word = {16'(k), 16'(-k)};
            tab[k].exp_data = {16'(k), 16'(-k)};
            tab[k].exp_last = (k == N - 1);
            tab[k].exp_cyc  = 3 + k;
        end
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // nominal frame, ready held high
        for (int k = 0; k < N; k++) ram[0][k] = tab[k].ram_word;
        run_frame(0, 1'b0, 0, 0);
        eq("first_req_cycle", first_req[0], 1);
        eq("first_valid_cycle", first_vld[0], 3);
        eq("busy_first_cycle", busy_first[0], 1);
        eq("busy_last_cycle", busy_last[0], N + 2);
        eq("done_cycle", done_c[0], N + 3);
        eq("nominal_count", got_n[0], N);
        for (int k = 0; k < N; k++) begin
            eq($sformatf("tab%0d_data", k), got_d[0][k], tab[k].exp_data);
            eq($sformatf("tab%0d_last", k), got_l[0][k], tab[k].exp_last);
            eq($sformatf("tab%0d_cycle", k), got_c[0][k], tab[k].exp_cyc);
        end

        // same frame under random backpressure
        run_frame(0, 1'b1, 0, 0);
        compare_frame(0);

        // half spectrum with scaling
        for (int k = 0; k < N; k++) ram[1][k] = $urandom;
        ram[1][0] = 32'hFFF9_000D;
        run_frame(1, 1'b1, 0, 0);
        compare_frame(1);
        eq("scale_bin0", got_d[1][0], 32'hFFFE_0003);

        // random contents and ready on both instances
        for (int f = 0; f < 3; f++) begin
            for (int g = 0; g < 2; g++) begin
                for (int k = 0; k < N; k++) ram[g][k] = $urandom;
                run_frame(g, 1'b1, 0, 0);
                compare_frame(g);
            end
        end

        // second start mid-frame must not disturb the frame
        for (int k = 0; k < N; k++) ram[0][k] = tab[k].ram_word;
        run_frame(0, 1'b0, 4, 0);
        compare_frame(0);
        eq("mid_start_done_cycle", done_c[0], N + 3);

        // reset after three bins, then a full replay
        run_frame(0, 1'b0, 0, 3);
        for (int k = 0; k < 3; k++) begin
            eq($sformatf("pre_rst_bin%0d", k), got_d[0][k], tab[k].exp_data);
        end
        run_frame(0, 1'b0, 0, 0);
        compare_frame(0);
        eq("replay_first_cycle", got_c[0][0], 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
